// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite register slave: response codes,
// FSM state encodings and the write/read response helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel: address and data beats may arrive in either order.
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wstate_t;

  // Read channel: one outstanding read at a time.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  // A write is refused when it misses the register file or hits a
  // bus-read-only register.
  function automatic logic [1:0] wr_resp(input logic in_range, input logic ro);
    return (!in_range || ro) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_reg_decode.sv
// Combinational address decoder: byte address -> register index,
// in-range flag and read-only flag. Sub-word address bits are ignored.
module axil_reg_decode
  import axil_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [$clog2(NUM_REGS)-1:0] idx,
  output logic                        in_range,
  output logic                        ro
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int TOP   = OFF + IDX_W;

  assign idx = addr[OFF +: IDX_W];

  // Any set bit above the register window means the access misses.
  generate
    if (ADDR_WIDTH > TOP) begin : g_hi
      assign in_range = ~|addr[ADDR_WIDTH-1:TOP];
    end else begin : g_no_hi
      assign in_range = 1'b1;
    end
  endgenerate

  assign ro = RO_MASK[idx];

  // Byte-lane bits within a register word carry no meaning here.
  logic unused_low;
  assign unused_low = ^addr[OFF-1:0];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file slave with per-byte strobes, bus-read-only
// registers, a hardware write port and a per-register write pulse.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,   // 32 or 64
  parameter int                  NUM_REGS   = 16,   // power of two, 2..256
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  // ---------------- write channel state ----------------
  wstate_t               wstate_reg;
  logic                  awready_reg;
  logic                  wready_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]     wstrb_reg;

  // ---------------- read channel state ----------------
  rstate_t               rstate_reg;
  logic                  arready_reg;
  logic                  rvalid_reg;
  logic [1:0]            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Current register contents, one word per register.
  logic [DATA_WIDTH-1:0] regs_arr [NUM_REGS];

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic wr_commit;
  logic wr_ok;

  assign aw_hs = AWVALID && awready_reg;
  assign w_hs  = WVALID  && wready_reg;
  assign ar_hs = ARVALID && arready_reg;

  // The beat completing a write may come straight off the bus this cycle,
  // so use live address/data when that channel handshakes, else the latch.
  logic [ADDR_WIDTH-1:0] wr_addr_eff;
  logic [DATA_WIDTH-1:0] wr_data_eff;
  logic [STRB_W-1:0]     wr_strb_eff;

  assign wr_addr_eff = aw_hs ? AWADDR : awaddr_reg;
  assign wr_data_eff = w_hs  ? WDATA  : wdata_reg;
  assign wr_strb_eff = w_hs  ? WSTRB  : wstrb_reg;

  // Both beats present on this edge: the register update happens now.
  assign wr_commit = ((wstate_reg == W_IDLE)    && aw_hs && w_hs) ||
                     ((wstate_reg == W_HAVE_AW) && w_hs)          ||
                     ((wstate_reg == W_HAVE_W)  && aw_hs);

  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             wr_ro;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic             rd_ro_unused;

  axil_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wr_decode (
    .addr     (wr_addr_eff),
    .idx      (wr_idx),
    .in_range (wr_in_range),
    .ro       (wr_ro)
  );

  axil_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_rd_decode (
    .addr     (ARADDR),
    .idx      (rd_idx),
    .in_range (rd_in_range),
    .ro       (rd_ro_unused)
  );

  assign wr_ok = wr_commit && wr_in_range && !wr_ro;

  // Write FSM: collect AW and W in any order, respond, then wait for BREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate_reg  <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      if (aw_hs) awaddr_reg <= AWADDR;
      if (w_hs) begin
        wdata_reg <= WDATA;
        wstrb_reg <= WSTRB;
      end
      case (wstate_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          wready_reg  <= 1'b1;
          if (aw_hs && w_hs) begin
            wstate_reg  <= W_RESP;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_resp(wr_in_range, wr_ro);
          end else if (aw_hs) begin
            wstate_reg  <= W_HAVE_AW;
            awready_reg <= 1'b0;
          end else if (w_hs) begin
            wstate_reg <= W_HAVE_W;
            wready_reg <= 1'b0;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            wstate_reg <= W_RESP;
            wready_reg <= 1'b0;
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_resp(wr_in_range, wr_ro);
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            wstate_reg  <= W_RESP;
            awready_reg <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_resp(wr_in_range, wr_ro);
          end
        end
        W_RESP: begin
          if (BREADY) begin
            wstate_reg  <= W_IDLE;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        default: wstate_reg <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture data on the AR handshake, hold it until RREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate_reg  <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      case (rstate_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_hs) begin
            rstate_reg  <= R_RESP;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            // Register array is sampled before any same-edge write lands.
            rdata_reg   <= rd_in_range ? regs_arr[rd_idx] : '0;
            rresp_reg   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rstate_reg  <= R_IDLE;
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
          end
        end
        default: rstate_reg <= R_IDLE;
      endcase
    end
  end

  // Register storage: bus bytes take priority over the hardware port.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  wr_pulse_reg;
      logic                  hit;

      assign hit = wr_ok && (wr_idx == IDX_W'(gi));

      // Per-byte merge of bus write and hardware load; pulse on bus change.
      always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
          q_reg        <= '0;
          wr_pulse_reg <= 1'b0;
        end else begin
          for (int b = 0; b < STRB_W; b++) begin
            if (hit && wr_strb_eff[b])
              q_reg[b*8 +: 8] <= wr_data_eff[b*8 +: 8];
            else if (hw_we[gi])
              q_reg[b*8 +: 8] <= hw_wdata[gi*DATA_WIDTH + b*8 +: 8];
          end
          wr_pulse_reg <= hit && (|wr_strb_eff);
        end
      end

      assign regs_arr[gi]                          = q_reg;
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH]    = q_reg;
      assign reg_wr[gi]                            = wr_pulse_reg;
    end
  endgenerate

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RDATA   = rdata_reg;
  assign RRESP   = rresp_reg;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (32-bit data, 16 registers, reg 1 RO).
module tb_axil_reg_slave;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         AWVALID, AWREADY;
  logic [31:0]  AWADDR;
  logic         WVALID, WREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         BVALID, BREADY;
  logic [1:0]   BRESP;
  logic         ARVALID, ARREADY;
  logic [31:0]  ARADDR;
  logic         RVALID, RREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr;
  logic [15:0]  hw_we;
  logic [511:0] hw_wdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] model [16];

  always #5 ACLK = ~ACLK;

  axil_reg_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .RO_MASK    (16'h0002)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BRESP    (BRESP),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARADDR   (ARADDR),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .reg_q    (reg_q),
    .reg_wr   (reg_wr),
    .hw_we    (hw_we),
    .hw_wdata (hw_wdata)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] rq(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("%s_reg%0d", tag, i), rq(i), model[i]);
  endtask

  // Issue one write; AW and W start after their own delays. hw_mask is
  // driven on hw_we on the edge where the write commits.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic [15:0] hw_mask,
                           output logic [1:0] resp, output logic [15:0] pulse,
                           output logic [15:0] pulse_after, output logic bv_now);
    bit aw_pend = 1'b1;
    bit w_pend  = 1'b1;
    bit aw_fire, w_fire;
    int cyc = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb; BREADY = 1'b1;
    while ((aw_pend || w_pend) && cyc < 40) begin
      AWVALID = aw_pend && (cyc >= aw_dly);
      WVALID  = w_pend && (cyc >= w_dly);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      if ((!aw_pend || aw_fire) && (!w_pend || w_fire)) hw_we = hw_mask;
      tick();
      hw_we = '0;
      if (aw_fire) aw_pend = 1'b0;
      if (w_fire)  w_pend  = 1'b0;
      cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    pulse  = reg_wr;
    bv_now = BVALID;
    cyc = 0;
    while (!BVALID && cyc < 20) begin
      tick();
      cyc++;
    end
    check_val("wr_done", {62'd0, aw_pend || w_pend, !BVALID}, 64'd0);
    resp = BRESP;
    tick();
    pulse_after = reg_wr;
    $display("write addr=%08h data=%08h strb=%h resp=%0d pulse=%04h", addr, data, strb, resp, pulse);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    ARADDR = addr; RREADY = 1'b1; ARVALID = 1'b1;
    while (!ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    ARVALID = 1'b0;
    check_val("rd_latency", {63'd0, RVALID}, 64'd1);
    data = RDATA;
    resp = RRESP;
    tick();
    $display("read  addr=%08h data=%08h resp=%0d", addr, data, resp);
  endtask

  logic [1:0]  resp;
  logic [15:0] pulse, pulse_after;
  logic        bv_now;
  logic [31:0] rdata;

  initial begin
    ARESETN = 1'b0; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0; hw_we = '0; hw_wdata = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    tick(); tick();

    // Reset state
    check_val("rst_awready", {63'd0, AWREADY}, 0);
    check_val("rst_arready", {63'd0, ARREADY}, 0);
    check_val("rst_bvalid",  {63'd0, BVALID}, 0);
    check_val("rst_rvalid",  {63'd0, RVALID}, 0);
    check_val("rst_rdata",   {32'd0, RDATA}, 0);
    check_val("rst_reg_wr",  {48'd0, reg_wr}, 0);
    check_all_regs("rst");
    ARESETN = 1'b1;
    tick();
    check_val("rel_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'h7);

    // AW and W together to 0x08
    bus_write(32'h08, 32'hA5A5_1234, 4'hF, 0, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    model[2] = 32'hA5A5_1234;
    check_val("t1_bresp", {62'd0, resp}, 0);
    check_val("t1_bvalid_lat", {63'd0, bv_now}, 1);
    check_val("t1_pulse", {48'd0, pulse}, 64'h0004);
    check_val("t1_pulse_after", {48'd0, pulse_after}, 0);
    check_val("t1_reg2", rq(2), model[2]);
    bus_read(32'h08, rdata, resp);
    check_val("t1_rdata", rdata, 32'hA5A5_1234);
    check_val("t1_rresp", {62'd0, resp}, 0);

    // W three cycles ahead of AW, alternate byte strobes
    bus_write(32'h0C, 32'hFFFF_FFFF, 4'b0101, 3, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    model[3] = 32'h00FF_00FF;
    check_val("t2_bresp", {62'd0, resp}, 0);
    check_val("t2_pulse", {48'd0, pulse}, 64'h0008);
    check_val("t2_reg3", rq(3), 32'h00FF_00FF);

    // AW two cycles ahead of W, upper bytes only
    bus_write(32'h1C, 32'hCAFE_F00D, 4'b1100, 0, 2, 16'h0, resp, pulse, pulse_after, bv_now);
    model[7] = 32'hCAFE_0000;
    check_val("t3_bresp", {62'd0, resp}, 0);
    check_val("t3_pulse", {48'd0, pulse}, 64'h0080);
    check_val("t3_reg7", rq(7), 32'hCAFE_0000);

    // Zero strobe: OKAY, nothing modified, no pulse
    bus_write(32'h08, 32'h0000_0000, 4'h0, 0, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    check_val("t4_bresp", {62'd0, resp}, 0);
    check_val("t4_pulse", {48'd0, pulse}, 0);
    check_val("t4_reg2", rq(2), 32'hA5A5_1234);

    // Out-of-range write and read
    bus_write(32'h40, 32'h1234_5678, 4'hF, 0, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    check_val("t5_bresp", {62'd0, resp}, 64'h2);
    check_val("t5_pulse", {48'd0, pulse}, 0);
    check_all_regs("t5");
    bus_read(32'h40, rdata, resp);
    check_val("t5_rdata", rdata, 0);
    check_val("t5_rresp", {62'd0, resp}, 64'h2);

    // Read-only register 1: bus write refused, hardware load accepted
    bus_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    check_val("t6_bresp", {62'd0, resp}, 64'h2);
    check_val("t6_pulse", {48'd0, pulse}, 0);
    check_val("t6_reg1", rq(1), 0);
    hw_wdata[1*32 +: 32] = 32'h0000_0055;
    hw_we = 16'h0002;
    tick();
    hw_we = '0;
    model[1] = 32'h55;
    check_val("t6_hw_no_pulse", {48'd0, reg_wr}, 0);
    bus_read(32'h04, rdata, resp);
    check_val("t6_rdata", rdata, 32'h55);
    check_val("t6_rresp", {62'd0, resp}, 0);

    // Bus write and hardware load to register 6 on the same edge
    hw_wdata[6*32 +: 32] = 32'hDEAD_BEEF;
    bus_write(32'h18, 32'h1234_5678, 4'b0011, 0, 0, 16'h0040, resp, pulse, pulse_after, bv_now);
    model[6] = 32'hDEAD_5678;
    check_val("t7_pulse", {48'd0, pulse}, 64'h0040);
    check_val("t7_reg6", rq(6), 32'hDEAD_5678);

    // Stalled responses; read captured on the same edge as the write
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = 32'h14; WDATA = 32'h1111_2222; WSTRB = 4'hF; ARADDR = 32'h14;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    model[5] = 32'h1111_2222;
    AWADDR = 32'h20; WDATA = 32'h9999_9999; ARADDR = 32'h08;
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t8_bvalid%0d", k), {63'd0, BVALID}, 1);
      check_val($sformatf("t8_bresp%0d", k), {62'd0, BRESP}, 0);
      check_val($sformatf("t8_rvalid%0d", k), {63'd0, RVALID}, 1);
      check_val($sformatf("t8_rdata%0d", k), RDATA, 32'h0);
      check_val($sformatf("t8_ready%0d", k), {61'd0, AWREADY, WREADY, ARREADY}, 0);
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    check_val("t8_released", {62'd0, BVALID, RVALID}, 0);
    check_all_regs("t8");
    bus_read(32'h14, rdata, resp);
    check_val("t8_rdata_after", rdata, 32'h1111_2222);
    bus_read(32'h0E, rdata, resp);
    check_val("t8_lowbits_ignored", rdata, 32'h00FF_00FF);

    // Reset while holding only the write address
    AWADDR = 32'h0C; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check_val("t9_have_aw", {62'd0, AWREADY, WREADY}, 64'h1);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    check_val("t9_rst_bvalid", {63'd0, BVALID}, 0);
    check_all_regs("t9");
    tick();
    check_val("t9_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'h7);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("t9_no_bvalid%0d", k), {63'd0, BVALID}, 0);
      tick();
    end
    bus_write(32'h0C, 32'h0BAD_CAFE, 4'hF, 0, 0, 16'h0, resp, pulse, pulse_after, bv_now);
    check_val("t9_bresp", {62'd0, resp}, 0);
    check_val("t9_pulse", {48'd0, pulse}, 64'h0008);
    bus_read(32'h0C, rdata, resp);
    check_val("t9_rdata", rdata, 32'h0BAD_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
